// File: rtl/prbs_bit_scheduler.sv
// PRBS bit-boundary scheduler: paces lfsr_clk_enable at a configurable bit period
// and shadows the edge-time setting so the edge shaper only sees changes on bit boundaries.
module prbs_bit_scheduler #(
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic                dac_clk,
    input  logic                reset,
    input  logic                cfg_run,
    input  logic                cfg_update,
    input  logic [PERIOD_W-1:0] cfg_bit_period,
    input  logic [7:0]          cfg_edge_time,
    output logic                lfsr_clk_enable,
    output logic [7:0]          prbs_edge_time_config_reg,
    output logic                cfg_ack,
    output logic                edge_clamped,
    output logic [31:0]         bit_count,
    output logic [1:0]          sched_state_dbg
);

    localparam int unsigned         CW    = (PERIOD_W > 8) ? PERIOD_W : 8;
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LOAD     = 2'b01,
        RUN      = 2'b10,
        STOPPING = 2'b11
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PERIOD_W-1:0] counter;
    logic [PERIOD_W-1:0] shadow_period;
    logic                pending;

    logic [PERIOD_W-1:0] req_period;
    logic [CW-1:0]       req_limit;
    logic                req_clamp;
    logic [7:0]          req_edge;

    // Effective period and edge time derived from the live cfg inputs.
    always_comb begin
        req_period = (cfg_bit_period < MIN_P) ? MIN_P : cfg_bit_period;
        req_limit  = CW'(req_period - ONE_P);
        req_clamp  = (req_limit < CW'(255)) && (CW'(cfg_edge_time) > req_limit);
        req_edge   = req_clamp ? req_limit[7:0] : cfg_edge_time;
    end

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (cfg_run) state_next = LOAD;
            LOAD:     state_next = RUN;
            RUN:      if (!cfg_run) state_next = STOPPING;
            STOPPING: begin
                if (cfg_run) begin
                    state_next = RUN;
                end else if (counter == '0) begin
                    state_next = IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        lfsr_clk_enable = ((state == RUN) || (state == STOPPING)) && (counter == '0);
        sched_state_dbg = state;
    end

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            counter                   <= '0;
            shadow_period             <= MIN_P;
            pending                   <= 1'b0;
            cfg_ack                   <= 1'b0;
            edge_clamped              <= 1'b0;
            bit_count                 <= '0;
            prbs_edge_time_config_reg <= '0;
        end else begin
            cfg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_update) begin
                        shadow_period             <= req_period;
                        prbs_edge_time_config_reg <= req_edge;
                        edge_clamped              <= req_clamp;
                        cfg_ack                   <= 1'b1;
                    end
                end
                LOAD: begin
                    shadow_period             <= req_period;
                    prbs_edge_time_config_reg <= req_edge;
                    edge_clamped              <= req_clamp;
                    counter                   <= req_period - ONE_P;
                    bit_count                 <= '0;
                    pending                   <= 1'b0;
                end
                RUN, STOPPING: begin
                    if (lfsr_clk_enable) begin
                        bit_count <= bit_count + 32'd1;
                        // A request seen on the boundary itself is applied right away.
                        if (pending || cfg_update) begin
                            shadow_period             <= req_period;
                            prbs_edge_time_config_reg <= req_edge;
                            edge_clamped              <= req_clamp;
                            counter                   <= req_period - ONE_P;
                            cfg_ack                   <= 1'b1;
                            pending                   <= 1'b0;
                        end else begin
                            counter <= shadow_period - ONE_P;
                        end
                    end else begin
                        counter <= counter - ONE_P;
                        if (cfg_update) pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_bit_scheduler.sv
// Scoreboard bench: expected pulse and ack cycles are queued as stimulus is applied,
// and popped by a monitor whenever the scheduler produces a pulse or ack.
module tb_prbs_bit_scheduler;

    logic        dac_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_run = 1'b0;
    logic        cfg_update = 1'b0;
    logic [15:0] cfg_bit_period = '0;
    logic [7:0]  cfg_edge_time = '0;
    logic        lfsr_clk_enable;
    logic [7:0]  prbs_edge_time_config_reg;
    logic        cfg_ack;
    logic        edge_clamped;
    logic [31:0] bit_count;
    logic [1:0]  sched_state_dbg;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int pulse_q[$];
    int ack_q[$];

    prbs_bit_scheduler #(.PERIOD_W(16), .MIN_PERIOD(2)) dut (
        .dac_clk                   (dac_clk),
        .reset                     (reset),
        .cfg_run                   (cfg_run),
        .cfg_update                (cfg_update),
        .cfg_bit_period            (cfg_bit_period),
        .cfg_edge_time             (cfg_edge_time),
        .lfsr_clk_enable           (lfsr_clk_enable),
        .prbs_edge_time_config_reg (prbs_edge_time_config_reg),
        .cfg_ack                   (cfg_ack),
        .edge_clamped              (edge_clamped),
        .bit_count                 (bit_count),
        .sched_state_dbg           (sched_state_dbg)
    );

    always #5 dac_clk = ~dac_clk;
    always @(posedge dac_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic start(input int per, input int edge_t, output int t);
        cfg_bit_period = 16'(per);
        cfg_edge_time  = 8'(edge_t);
        cfg_run        = 1'b1;
        t              = cyc;
    endtask

    task automatic idle_update(input int per, input int edge_t);
        cfg_bit_period = 16'(per);
        cfg_edge_time  = 8'(edge_t);
        cfg_update     = 1'b1;
        ack_q.push_back(cyc + 1);
        tick();
        cfg_update = 1'b0;
    endtask

    always @(negedge dac_clk) begin
        if (lfsr_clk_enable) begin
            if (pulse_q.size() == 0) check("unexpected_pulse", cyc, -1);
            else check("pulse_cycle", cyc, pulse_q.pop_front());
        end
        if (cfg_ack) begin
            if (ack_q.size() == 0) check("unexpected_ack", cyc, -1);
            else check("ack_cycle", cyc, ack_q.pop_front());
        end
    end

    initial begin
        int t;
        tick();
        tick();
        check("rst_state", sched_state_dbg, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_edge", prbs_edge_time_config_reg, 0);
        check("rst_clamped", edge_clamped, 0);
        check("rst_ack", cfg_ack, 0);
        check("rst_enable", lfsr_clk_enable, 0);
        reset = 1'b0;
        tick();

        // Basic timing: period 10, edge 4
        start(10, 4, t);
        pulse_q.push_back(t + 11);
        pulse_q.push_back(t + 21);
        pulse_q.push_back(t + 31);
        tick();
        check("load_state", sched_state_dbg, 1);
        tick();
        check("run_state", sched_state_dbg, 2);
        check("p10_edge", prbs_edge_time_config_reg, 4);
        check("p10_clamped", edge_clamped, 0);
        wait_until(t + 33);
        check("p10_bit_count", bit_count, 3);
        cfg_run = 1'b0;
        pulse_q.push_back(t + 41);
        wait_until(t + 42);
        check("p10_idle", sched_state_dbg, 0);
        check("p10_bit_count_end", bit_count, 4);
        check("p10_pulses_left", pulse_q.size(), 0);

        // Period below minimum
        start(0, 0, t);
        for (int i = 0; i < 4; i++) pulse_q.push_back(t + 3 + 2 * i);
        wait_until(t + 8);
        cfg_run = 1'b0;
        wait_until(t + 10);
        check("p0_idle", sched_state_dbg, 0);
        check("p0_pulses_left", pulse_q.size(), 0);

        // Edge clamp at load
        start(5, 200, t);
        pulse_q.push_back(t + 6);
        pulse_q.push_back(t + 11);
        wait_until(t + 2);
        check("p5_edge", prbs_edge_time_config_reg, 4);
        check("p5_clamped", edge_clamped, 1);
        wait_until(t + 7);
        cfg_run = 1'b0;
        wait_until(t + 12);
        check("p5_idle", sched_state_dbg, 0);
        check("p5_bit_count", bit_count, 2);
        check("p5_pulses_left", pulse_q.size(), 0);

        // Updates in IDLE: large period never clamps, then a clamping one
        idle_update(300, 250);
        check("idle_upd_edge", prbs_edge_time_config_reg, 250);
        check("idle_upd_clamped", edge_clamped, 0);
        tick();
        idle_update(200, 250);
        check("idle_upd2_edge", prbs_edge_time_config_reg, 199);
        check("idle_upd2_clamped", edge_clamped, 1);
        tick();
        check("idle_acks_left", ack_q.size(), 0);

        // Mid-bit update in RUN: P=8 -> P=3
        start(8, 1, t);
        pulse_q.push_back(t + 9);
        pulse_q.push_back(t + 17);
        pulse_q.push_back(t + 20);
        pulse_q.push_back(t + 23);
        wait_until(t + 12);
        cfg_bit_period = 16'd3;
        cfg_edge_time  = 8'd7;
        cfg_update     = 1'b1;
        ack_q.push_back(t + 18);
        tick();
        cfg_update = 1'b0;
        wait_until(t + 17);
        check("upd_edge_before", prbs_edge_time_config_reg, 1);
        tick();
        check("upd_edge_after", prbs_edge_time_config_reg, 2);
        check("upd_clamped", edge_clamped, 1);
        wait_until(t + 21);
        cfg_run = 1'b0;
        wait_until(t + 24);
        check("upd_idle", sched_state_dbg, 0);
        check("upd_pulses_left", pulse_q.size(), 0);

        // Stop two cycles after a pulse, P=6
        start(6, 2, t);
        pulse_q.push_back(t + 7);
        pulse_q.push_back(t + 13);
        pulse_q.push_back(t + 19);
        wait_until(t + 15);
        cfg_run = 1'b0;
        tick();
        check("stop_state", sched_state_dbg, 3);
        wait_until(t + 20);
        check("stop_idle", sched_state_dbg, 0);
        check("stop_pulses_left", pulse_q.size(), 0);

        // Stop then resume before the pending pulse
        start(6, 2, t);
        for (int i = 0; i < 5; i++) pulse_q.push_back(t + 7 + 6 * i);
        wait_until(t + 15);
        cfg_run = 1'b0;
        wait_until(t + 17);
        cfg_run = 1'b1;
        tick();
        check("resume_state", sched_state_dbg, 2);
        wait_until(t + 26);
        cfg_run = 1'b0;
        wait_until(t + 32);
        check("resume_idle", sched_state_dbg, 0);
        check("resume_pulses_left", pulse_q.size(), 0);

        // Reset mid-bit with an update pending
        start(8, 3, t);
        pulse_q.push_back(t + 9);
        wait_until(t + 11);
        cfg_bit_period = 16'd4;
        cfg_update     = 1'b1;
        tick();
        cfg_update = 1'b0;
        wait_until(t + 13);
        reset = 1'b1;
        tick();
        check("mid_rst_state", sched_state_dbg, 0);
        check("mid_rst_bit_count", bit_count, 0);
        check("mid_rst_edge", prbs_edge_time_config_reg, 0);
        check("mid_rst_clamped", edge_clamped, 0);
        check("mid_rst_ack", cfg_ack, 0);
        check("mid_rst_enable", lfsr_clk_enable, 0);
        reset = 1'b0;
        pulse_q.push_back(t + 19);
        pulse_q.push_back(t + 23);
        pulse_q.push_back(t + 27);
        wait_until(t + 24);
        cfg_run = 1'b0;
        wait_until(t + 28);
        check("mid_rst_idle", sched_state_dbg, 0);
        check("mid_rst_pulses_left", pulse_q.size(), 0);

        // bit_count wrap via backdoor
        start(8, 0, t);
        pulse_q.push_back(t + 9);
        pulse_q.push_back(t + 17);
        wait_until(t + 10);
        force dut.bit_count = 32'hFFFF_FFFF;
        tick();
        release dut.bit_count;
        tick();
        check("wrap_preset", bit_count, 64'h0000_0000_FFFF_FFFF);
        wait_until(t + 18);
        check("wrap_bit_count", bit_count, 0);
        cfg_run = 1'b0;
        pulse_q.push_back(t + 25);
        wait_until(t + 26);
        check("wrap_idle", sched_state_dbg, 0);
        check("wrap_pulses_left", pulse_q.size(), 0);

        check("acks_left", ack_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
